// File: rtl/logic_op_finder.sv
// Finds the 3-bit logic op f(A,B) whose output best matches a target image (minimum pixel mismatches).
// One image row per clock: 8*ImageHeight RUN cycles, done pulses ImageHeight*8+1 cycles after the accepting edge.
// start is accepted only in IDLE and is ignored (not queued) while busy or during the done cycle.
module logic_op_finder #(
    parameter int ImageWidth  = 8,
    parameter int ImageHeight = 8
) (
    input  logic                                                   clk,
    input  logic                                                   rst_n,
    input  logic                                                   start,
    input  logic [ImageWidth*ImageHeight-1:0]                      imgA,
    input  logic [ImageWidth*ImageHeight-1:0]                      imgB,
    input  logic [ImageWidth*ImageHeight-1:0]                      target,
    output logic                                                   busy,
    output logic                                                   done,
    output logic [2:0]                                             bestOp,
    output logic [$clog2(ImageWidth*ImageHeight+1)-1:0]            bestErr,
    output logic                                                   exact
);
    localparam int ErrWidth = $clog2(ImageWidth*ImageHeight+1);
    localparam int NumPix   = ImageWidth * ImageHeight;
    localparam int RowWidth = (ImageHeight > 1) ? $clog2(ImageHeight) : 1;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] RUN     = 2'd1;
    localparam logic [1:0] DONE_ST = 2'd2;

    logic [1:0]              state;
    logic [NumPix-1:0]       a_img, b_img, t_img;
    logic [2:0]              op;
    logic [RowWidth-1:0]     row;
    logic [ErrWidth-1:0]     acc;
    logic [2:0]              cand_op;
    logic [ErrWidth-1:0]     cand_err;
    logic [2:0]              best_op_q;
    logic [ErrWidth-1:0]     best_err_q;
    logic                    exact_q;
    logic [ErrWidth-1:0]     op_err [0:7];

    logic [ImageWidth-1:0]   a_row, b_row, t_row, f_row, diff_row;
    logic [ErrWidth-1:0]     row_err, total;
    logic                    last_row, better;
    logic [ErrWidth-1:0]     final_err;
    logic [2:0]              final_op;

    // Images rotate right by one row each RUN cycle, so the current row is always the low slice
    // and after ImageHeight cycles the original ordering is restored for the next op.
    function automatic logic [NumPix-1:0] rot_row(input logic [NumPix-1:0] img);
        logic [2*NumPix-1:0] dbl;
        dbl = {img, img};
        return dbl[ImageWidth +: NumPix];
    endfunction

    always_comb begin
        a_row = a_img[ImageWidth-1:0];
        b_row = b_img[ImageWidth-1:0];
        t_row = t_img[ImageWidth-1:0];
        f_row = '0;
        case (op)
            3'b000:  f_row = a_row;
            3'b001:  f_row = b_row;
            3'b010:  f_row = ~a_row;
            3'b011:  f_row = ~b_row;
            3'b100:  f_row = a_row & b_row;
            3'b101:  f_row = a_row | b_row;
            3'b110:  f_row = a_row ^ b_row;
            default: f_row = ~(a_row ^ b_row);
        endcase
        diff_row = f_row ^ t_row;
        row_err  = '0;
        for (int i = 0; i < ImageWidth; i++) begin
            row_err = row_err + ErrWidth'(diff_row[i]);
        end
        total     = acc + row_err;
        last_row  = (row == RowWidth'(ImageHeight - 1));
        better    = (total < cand_err);
        final_op  = better ? op : cand_op;
        final_err = better ? total : cand_err;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            a_img      <= '0;
            b_img      <= '0;
            t_img      <= '0;
            op         <= '0;
            row        <= '0;
            acc        <= '0;
            cand_op    <= '0;
            cand_err   <= '0;
            best_op_q  <= '0;
            best_err_q <= '0;
            exact_q    <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                op_err[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_img    <= imgA;
                        b_img    <= imgB;
                        t_img    <= target;
                        op       <= '0;
                        row      <= '0;
                        acc      <= '0;
                        cand_op  <= '0;
                        cand_err <= '1;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    a_img <= rot_row(a_img);
                    b_img <= rot_row(b_img);
                    t_img <= rot_row(t_img);
                    if (!last_row) begin
                        acc <= total;
                        row <= row + RowWidth'(1);
                    end else begin
                        op_err[op] <= total;
                        acc        <= '0;
                        row        <= '0;
                        op         <= op + 3'd1;
                        // Strict compare keeps the lowest op code on ties.
                        if (better) begin
                            cand_op  <= op;
                            cand_err <= total;
                        end
                        if (op == 3'd7) begin
                            best_op_q  <= final_op;
                            best_err_q <= final_err;
                            exact_q    <= (final_err == '0);
                            state      <= DONE_ST;
                        end
                    end
                end
                DONE_ST: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign busy    = (state == RUN);
    assign done    = (state == DONE_ST);
    assign bestOp  = best_op_q;
    assign bestErr = best_err_q;
    assign exact   = exact_q;
endmodule

// File: tb/tb_logic_op_finder.sv
// Directed bench for logic_op_finder: default 8x8 instance plus a 4x1 instance.
module tb_logic_op_finder;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [63:0] imgA = '0, imgB = '0, target = '0;
    logic        busy, done, exact;
    logic [2:0]  bestOp;
    logic [6:0]  bestErr;

    logic        s_start = 1'b0;
    logic [3:0]  s_a = '0, s_b = '0, s_t = '0;
    logic        s_busy, s_done, s_exact;
    logic [2:0]  s_op;
    logic [2:0]  s_err;

    int n_checks = 0;
    int n_fail   = 0;
    logic [2:0] last_op  = 3'd0;
    logic [6:0] last_err = 7'd0;

    always #5 clk = ~clk;

    logic_op_finder #(.ImageWidth(8), .ImageHeight(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .imgA(imgA), .imgB(imgB), .target(target),
        .busy(busy), .done(done), .bestOp(bestOp), .bestErr(bestErr), .exact(exact)
    );

    logic_op_finder #(.ImageWidth(4), .ImageHeight(1)) dut_small (
        .clk(clk), .rst_n(rst_n), .start(s_start), .imgA(s_a), .imgB(s_b), .target(s_t),
        .busy(s_busy), .done(s_done), .bestOp(s_op), .bestErr(s_err), .exact(s_exact)
    );

    function automatic logic [6:0] model_err(input logic [2:0] op, input logic [63:0] a,
                                             input logic [63:0] b, input logic [63:0] t);
        logic [63:0] r;
        logic [6:0]  c;
        case (op)
            3'd0: r = a;
            3'd1: r = b;
            3'd2: r = ~a;
            3'd3: r = ~b;
            3'd4: r = a & b;
            3'd5: r = a | b;
            3'd6: r = a ^ b;
            default: r = ~(a ^ b);
        endcase
        r = r ^ t;
        c = '0;
        for (int i = 0; i < 64; i++) c = c + {6'd0, r[i]};
        return c;
    endfunction

    task automatic start_run(input logic [63:0] a, input logic [63:0] b, input logic [63:0] t);
        @(negedge clk);
        imgA = a; imgB = b; target = t; start = 1'b1;
        @(posedge clk);
    endtask

    // Follows one run from the accepting edge; optionally scrambles inputs and re-pulses start mid-run.
    task automatic run_check(input string name, input logic [2:0] eop, input logic [6:0] eerr,
                             input logic eex, input bit inject);
        int   done_at = -1;
        int   dones = 0;
        bit   busy_ok = 1'b1;
        bit   hold_ok = 1'b1;
        logic [2:0] got_op = '0;
        logic [6:0] got_err = '0;
        logic       got_ex = 1'b0;
        for (int n = 1; n <= 70; n++) begin
            @(negedge clk);
            start = inject && (n == 3 || n == 40);
            if (start) begin
                imgA = {$urandom, $urandom}; imgB = {$urandom, $urandom}; target = {$urandom, $urandom};
            end
            if (busy !== (n <= 64)) busy_ok = 1'b0;
            if (n <= 64 && (bestOp !== last_op || bestErr !== last_err)) hold_ok = 1'b0;
            if (done === 1'b1) begin
                dones++;
                if (done_at < 0) begin
                    done_at = n; got_op = bestOp; got_err = bestErr; got_ex = exact;
                end
            end
        end
        start = 1'b0;
        n_checks++; if (busy_ok !== 1'b1) begin n_fail++; $display("FAIL %s busy window: busy not high exactly in cycles 1..64", name); end
        n_checks++; if (hold_ok !== 1'b1) begin n_fail++; $display("FAIL %s hold: outputs changed during RUN", name); end
        n_checks++; if (done_at !== 65 || dones !== 1) begin n_fail++; $display("FAIL %s done: first at %0d count %0d, required at 65 count 1", name, done_at, dones); end
        n_checks++; if (got_op !== eop) begin n_fail++; $display("FAIL %s bestOp: got %0d expected %0d", name, got_op, eop); end
        n_checks++; if (got_err !== eerr) begin n_fail++; $display("FAIL %s bestErr: got %0d expected %0d", name, got_err, eerr); end
        n_checks++; if (got_ex !== eex) begin n_fail++; $display("FAIL %s exact: got %0d expected %0d", name, got_ex, eex); end
        last_op = eop; last_err = eerr;
    endtask

    task automatic check_reset_outputs(input string name);
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || bestOp !== 3'd0 || bestErr !== 7'd0 || exact !== 1'b0) begin
            n_fail++;
            $display("FAIL %s: busy=%b done=%b op=%0d err=%0d exact=%b, expected all zero",
                     name, busy, done, bestOp, bestErr, exact);
        end
    endtask

    task automatic test_reset();
        #1;
        check_reset_outputs("reset_main");
        n_checks++;
        if (s_busy !== 1'b0 || s_done !== 1'b0 || s_op !== 3'd0 || s_err !== 3'd0 || s_exact !== 1'b0) begin
            n_fail++; $display("FAIL reset_small: outputs not at reset values");
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_tie();
        start_run({64{1'b1}}, 64'h0, 64'h0);
        run_check("tie", 3'd1, 7'd0, 1'b1, 1'b0);
    endtask

    task automatic test_xor_probes();
        logic [63:0] a, b;
        logic [6:0]  exp_tab [0:7];
        a = 64'hF0F0_F0F0_F0F0_F0F0;
        b = 64'hFF00_FF00_FF00_FF00;
        exp_tab = '{7'd32, 7'd32, 7'd32, 7'd32, 7'd48, 7'd16, 7'd0, 7'd64};
        start_run(a, b, a ^ b);
        run_check("xor", 3'd6, 7'd0, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (dut.op_err[i] !== exp_tab[i] || exp_tab[i] !== model_err(3'(i), a, b, a ^ b)) begin
                n_fail++;
                $display("FAIL op_err[%0d]: got %0d expected %0d", i, dut.op_err[i], exp_tab[i]);
            end
        end
    endtask

    task automatic test_single_bit();
        start_run(64'h0, 64'h0, 64'h1);
        run_check("single_bit", 3'd0, 7'd1, 1'b0, 1'b0);
    endtask

    task automatic test_input_isolation();
        logic [63:0] a, b, t;
        logic [6:0]  best_e, e;
        logic [2:0]  best_o;
        a = 64'h0123_4567_89AB_CDEF;
        b = 64'hFEDC_BA98_7654_3210;
        t = 64'h00FF_00FF_0F0F_0F0F;
        best_e = 7'h7F; best_o = 3'd0;
        for (int i = 0; i < 8; i++) begin
            e = model_err(3'(i), a, b, t);
            if (e < best_e) begin best_e = e; best_o = 3'(i); end
        end
        start_run(a, b, t);
        run_check("isolation", best_o, best_e, (best_e == 7'd0), 1'b1);
    endtask

    task automatic test_reset_mid_run();
        int dones = 0;
        start_run({64{1'b1}}, 64'h0, 64'h0);
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_run_reset");
        n_checks++;
        if (dut.op_err[0] !== 7'd0) begin n_fail++; $display("FAIL mid_run_reset op_err0: got %0d expected 0", dut.op_err[0]); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 70; n++) begin
            @(negedge clk);
            if (done === 1'b1) dones++;
        end
        n_checks++;
        if (dones !== 0) begin n_fail++; $display("FAIL no_done_after_reset: got %0d pulses expected 0", dones); end
        last_op = 3'd0; last_err = 7'd0;
        start_run({64{1'b1}}, 64'h0, 64'h0);
        run_check("after_reset", 3'd1, 7'd0, 1'b1, 1'b0);
    endtask

    task automatic test_small();
        int   done_at = -1;
        bit   busy_ok = 1'b1;
        logic [2:0] got_op = '0, got_err = '1;
        @(negedge clk);
        s_a = 4'b1010; s_b = 4'b0110; s_t = 4'b0010; s_start = 1'b1;
        @(posedge clk);
        for (int n = 1; n <= 14; n++) begin
            @(negedge clk);
            s_start = 1'b0;
            if (s_busy !== (n <= 8)) busy_ok = 1'b0;
            if (s_done === 1'b1 && done_at < 0) begin done_at = n; got_op = s_op; got_err = s_err; end
        end
        n_checks++; if (busy_ok !== 1'b1) begin n_fail++; $display("FAIL small busy window: not high exactly in cycles 1..8"); end
        n_checks++; if (done_at !== 9) begin n_fail++; $display("FAIL small done: at %0d expected 9", done_at); end
        n_checks++; if (got_op !== 3'd4) begin n_fail++; $display("FAIL small bestOp: got %0d expected 4", got_op); end
        n_checks++; if (got_err !== 3'd0 || s_exact !== 1'b1) begin n_fail++; $display("FAIL small err/exact: got %0d/%b expected 0/1", got_err, s_exact); end
    endtask

    initial begin
        test_reset();
        test_tie();
        test_xor_probes();
        test_single_bit();
        test_input_isolation();
        test_reset_mid_run();
        test_small();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
